// File: rtl/load_store_unit.sv
// Memory-stage load/store unit in front of the register-based Data_Mem.
// Handles one request at a time; byte stores use read-modify-write, and faulting requests never touch memory.
module load_store_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8,
    parameter int RD_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_byte,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [RD_W-1:0]   req_rd,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [RD_W-1:0]   rsp_rd,
    output logic [1:0]        rsp_fault,
    output logic              mem_wr_en,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] mem_Addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_STORE  = 3'd2;
    localparam logic [2:0] S_RMW_RD = 3'd3;
    localparam logic [2:0] S_RMW_WR = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(2 * DEPTH);

    logic [2:0]        state_q, state_d;
    logic              we_q, we_d, byte_q, byte_d, signed_q, signed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, merged_q, merged_d, rsp_data_q, rsp_data_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [1:0]        fault_q, fault_d;

    // Little-endian byte select plus zero/sign extension for byte loads.
    function automatic logic [DATA_W-1:0] load_value(input logic [DATA_W-1:0] word,
                                                     input logic hi, input logic is_byte,
                                                     input logic sgn);
        logic [7:0] b;
        b = hi ? word[15:8] : word[7:0];
        if (!is_byte) begin
            load_value = word;
        end else begin
            load_value = {{(DATA_W-8){sgn & b[7]}}, b};
        end
    endfunction

    function automatic logic [DATA_W-1:0] merge_byte(input logic [DATA_W-1:0] word,
                                                     input logic hi, input logic [7:0] b);
        merge_byte = hi ? {b, word[7:0]} : {word[15:8], b};
    endfunction

    // Next-state and datapath-register computation.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        byte_d     = byte_q;
        signed_d   = signed_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        fault_d    = fault_q;
        merged_d   = merged_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d       = req_we;
                    byte_d     = req_byte;
                    signed_d   = req_signed;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    rd_d       = req_rd;
                    rsp_data_d = '0;
                    // Range is checked before alignment.
                    if (req_addr >= ADDR_LIMIT) begin
                        fault_d = 2'b10;
                        state_d = S_RESP;
                    end else if (!req_byte && req_addr[0]) begin
                        fault_d = 2'b01;
                        state_d = S_RESP;
                    end else begin
                        fault_d = 2'b00;
                        if (!req_we) begin
                            state_d = S_LOAD;
                        end else if (req_byte) begin
                            state_d = S_RMW_RD;
                        end else begin
                            state_d = S_STORE;
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                rsp_data_d = load_value(mem_rd_data, addr_q[0], byte_q, signed_q);
                state_d    = S_RESP;
            end
            S_STORE:  state_d = S_RESP;
            S_RMW_RD: begin
                merged_d = merge_byte(mem_rd_data, addr_q[0], wdata_q[7:0]);
                state_d  = S_RMW_WR;
            end
            S_RMW_WR: state_d = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // State and request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            byte_q     <= 1'b0;
            signed_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            fault_q    <= 2'b00;
            merged_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            byte_q     <= byte_d;
            signed_q   <= signed_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            fault_q    <= fault_d;
            merged_q   <= merged_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Memory port decode; write enable is gated by rst so an in-flight write never commits.
    always_comb begin
        mem_read_en = (state_q == S_LOAD) || (state_q == S_RMW_RD);
        mem_wr_en   = !rst && ((state_q == S_STORE) || (state_q == S_RMW_WR));
        if ((state_q == S_LOAD) || (state_q == S_STORE) ||
            (state_q == S_RMW_RD) || (state_q == S_RMW_WR)) begin
            mem_Addr = {1'b0, addr_q[ADDR_W-1:1]};
        end else begin
            mem_Addr = '0;
        end
        case (state_q)
            S_STORE:  mem_wr_data = wdata_q;
            S_RMW_WR: mem_wr_data = merged_q;
            default:  mem_wr_data = '0;
        endcase
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_rd    = rd_q;
    assign rsp_fault = fault_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a word-array reference model predicts each response,
// and a negedge monitor pops and compares whenever a response handshake occurs.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_byte = 1'b0, req_signed = 1'b0;
    logic [15:0] req_addr = 16'h0, req_wdata = 16'h0;
    logic [2:0]  req_rd = 3'd0;
    logic        rsp_ready = 1'b1;
    logic        req_ready, rsp_valid, mem_wr_en, mem_read_en;
    logic [15:0] rsp_data, mem_Addr, mem_wr_data, mem_rd_data;
    logic [2:0]  rsp_rd;
    logic [1:0]  rsp_fault;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  rd;
        logic [1:0]  fault;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    logic [15:0] dmem [8];
    logic [15:0] ref_mem [8];
    logic        mem_clr = 1'b1;
    int          wr_cnt = 0, rd_cnt = 0;
    int          checks = 0, errors = 0;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_byte(req_byte),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
        .rsp_fault(rsp_fault), .mem_wr_en(mem_wr_en), .mem_read_en(mem_read_en),
        .mem_Addr(mem_Addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    // Data_Mem stand-in: combinational read, write commits at posedge.
    assign mem_rd_data = mem_read_en ? dmem[mem_Addr[2:0]] : 16'h0;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 8; i++) dmem[i] <= 16'h0;
        end else if (mem_wr_en) begin
            dmem[mem_Addr[2:0]] <= mem_wr_data;
        end
        if (mem_wr_en) wr_cnt <= wr_cnt + 1;
        if (mem_read_en) rd_cnt <= rd_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: predicts the response and memory effect from the request alone.
    task automatic model(input logic we, input logic bt, input logic sg,
                         input logic [15:0] a, input logic [15:0] wd, input logic [2:0] rd);
        exp_t e;
        int   idx, sh, b;
        e.rd = rd;
        e.data = 16'h0;
        idx = int'(a) / 2;
        sh = 8 * int'(a % 16'd2);
        if (a >= 16'd16) begin
            e.fault = 2'b10;
        end else if (!bt && a[0]) begin
            e.fault = 2'b01;
        end else begin
            e.fault = 2'b00;
            b = (int'(ref_mem[idx]) >> sh) & 255;
            if (!we && !bt) begin
                e.data = ref_mem[idx];
            end else if (!we) begin
                e.data = (sg && b >= 128) ? 16'(b + 65280) : 16'(b);
            end else if (!bt) begin
                ref_mem[idx] = wd;
            end else begin
                ref_mem[idx] = 16'((int'(ref_mem[idx]) & ~(255 << sh)) | ((int'(wd) & 255) << sh));
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic we, input logic bt, input logic sg, input logic [15:0] a,
                         input logic [15:0] wd, input logic [2:0] rd, output int lat);
        int n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
        req_we = we; req_byte = bt; req_signed = sg; req_addr = a; req_wdata = wd; req_rd = rd;
        req_valid = 1'b1;
        model(we, bt, sg, a, wd, rd);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            tick();
            lat++;
        end
        if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
    endtask

    // Monitor: compare every handshaken response against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
                chk("rsp_rd", 32'(rsp_rd), 32'(mon_e.rd));
                chk("rsp_fault", 32'(rsp_fault), 32'(mon_e.fault));
            end
        end
    end

    initial begin
        int lat, w0, r0, n;
        logic [15:0] sd;
        logic [2:0]  sr;
        logic [1:0]  sf;
        logic [15:0] a;
        for (int i = 0; i < 8; i++) ref_mem[i] = 16'h0;
        repeat (3) tick();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_all", 32'({rsp_data, rsp_rd, rsp_fault}), 32'd0);
        chk("rst_mem_all", 32'({mem_wr_en, mem_read_en, mem_Addr, mem_wr_data}), 32'd0);
        rst = 1'b0;
        mem_clr = 1'b0;
        tick();

        // Word store then load back.
        w0 = wr_cnt;
        issue(1'b1, 1'b0, 1'b0, 16'h0004, 16'hBEEF, 3'd1, lat);
        chk("word_store_lat", 32'(lat), 32'd2);
        tick();
        chk("word_store_mem2", 32'(dmem[2]), 32'hBEEF);
        chk("word_store_writes", 32'(wr_cnt - w0), 32'd1);
        issue(1'b0, 1'b0, 1'b0, 16'h0004, 16'h0, 3'd5, lat);
        chk("word_load_lat", 32'(lat), 32'd2);

        // Byte loads with sign/zero extension.
        issue(1'b1, 1'b0, 1'b0, 16'h0002, 16'h80FF, 3'd2, lat);
        issue(1'b0, 1'b1, 1'b1, 16'h0003, 16'h0, 3'd3, lat);
        chk("byte_load_lat", 32'(lat), 32'd2);
        issue(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0, 3'd4, lat);
        issue(1'b0, 1'b1, 1'b1, 16'h0002, 16'h0, 3'd7, lat);

        // Byte store read-modify-write.
        issue(1'b1, 1'b0, 1'b0, 16'h0006, 16'h1234, 3'd0, lat);
        tick();
        w0 = wr_cnt;
        issue(1'b1, 1'b1, 1'b0, 16'h0007, 16'h00AB, 3'd6, lat);
        chk("byte_store_lat", 32'(lat), 32'd3);
        tick();
        chk("byte_store_mem3", 32'(dmem[3]), 32'hAB34);
        chk("byte_store_writes", 32'(wr_cnt - w0), 32'd1);

        // Faults: no memory enable, 1-cycle latency.
        w0 = wr_cnt; r0 = rd_cnt;
        issue(1'b0, 1'b0, 1'b0, 16'h0005, 16'h0, 3'd1, lat);
        chk("misalign_lat", 32'(lat), 32'd1);
        issue(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0, 3'd2, lat);
        chk("range_lat", 32'(lat), 32'd1);
        issue(1'b1, 1'b1, 1'b0, 16'h0011, 16'h00CC, 3'd3, lat);
        tick();
        chk("fault_mem_enables", 32'((wr_cnt - w0) + (rd_cnt - r0)), 32'd0);

        // Back-pressure: response held, no new acceptance until handshake.
        rsp_ready = 1'b0;
        issue(1'b0, 1'b0, 1'b0, 16'h0004, 16'h0, 3'd6, lat);
        sd = rsp_data; sr = rsp_rd; sf = rsp_fault;
        req_we = 1'b0; req_byte = 1'b0; req_signed = 1'b0; req_addr = 16'h0000; req_rd = 3'd7;
        req_valid = 1'b1;
        model(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0, 3'd7);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rsp_stable", 32'({rsp_data, rsp_rd, rsp_fault}), 32'({sd, sr, sf}));
            chk("stall_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("post_hs_idle", 32'(req_ready), 32'd1);
        tick();
        chk("post_hs_accept", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin
            tick();
            n++;
        end
        chk("stall_second_rsp", 32'(rsp_valid), 32'd1);
        tick();

        // Reset during RMW_WR: write dropped, no response.
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        req_we = 1'b1; req_byte = 1'b1; req_signed = 1'b0; req_addr = 16'h0004;
        req_wdata = 16'h0055; req_rd = 3'd5; req_valid = 1'b1;
        w0 = wr_cnt;
        tick();
        req_valid = 1'b0;
        tick();
        chk("rmw_wr_reached", 32'(mem_wr_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_gates_wr_en", 32'(mem_wr_en), 32'd0);
        tick();
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_rsp", 32'({rsp_valid, rsp_data, rsp_rd, rsp_fault}), 32'd0);
        chk("midrst_mem", 32'({mem_wr_en, mem_read_en, mem_Addr, mem_wr_data}), 32'd0);
        rst = 1'b0;
        repeat (3) begin
            tick();
            chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        chk("midrst_mem2", 32'(dmem[2]), 32'(ref_mem[2]));
        chk("midrst_no_write", 32'(wr_cnt - w0), 32'd0);

        // Randomized traffic with random back-pressure.
        for (int k = 0; k < 200; k++) begin
            a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 19));
            rsp_ready = ($urandom_range(0, 2) != 0);
            issue(1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom), 3'($urandom), lat);
            repeat ($urandom_range(0, 3)) tick();
            rsp_ready = 1'b1;
            tick();
        end
        repeat (3) tick();
        for (int i = 0; i < 8; i++) chk("final_mem", 32'(dmem[i]), 32'(ref_mem[i]));
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
